sym_fir_tdm: RTL

- Time-multiplexed symmetric FIR for the audio path. Order N_TAP (N_TAP+1 taps), N_CH channels, one shared pre-add/multiply/accumulate datapath.
- Only the unique half of the coefficients is stored; they are runtime-loadable.
- Output is rounded and saturated to WD bits with a valid/ready input and a valid output pulse.
- Replaces the fully parallel fixed-coefficient FIR between the codec receive and transmit blocks.

---
 rtl/sym_fir_tdm_if.sv | 30 +++
 rtl/sym_fir_tdm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sym_fir_tdm_if.sv
// Frame, result and coefficient-load signals of the time-multiplexed symmetric FIR.
// The master drives frames and coefficients; the slave is the filter.
interface sym_fir_tdm_if #(
  parameter int WD    = 24,
  parameter int N_TAP = 32,
  parameter int N_CH  = 2
);
  localparam int U  = N_TAP / 2 + 1;
  localparam int AW = (U > 1) ? $clog2(U) : 1;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [N_CH*WD-1:0]   in_data_i;
  logic                 out_valid_o;
  logic [N_CH*WD-1:0]   out_data_o;
  logic                 coef_we_i;
  logic [AW-1:0]        coef_addr_i;
  logic [WD-1:0]        coef_data_i;
  logic                 busy_o;

  modport master (
    output in_valid_i, in_data_i, coef_we_i, coef_addr_i, coef_data_i,
    input  in_ready_o, out_valid_o, out_data_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_data_i, coef_we_i, coef_addr_i, coef_data_i,
    output in_ready_o, out_valid_o, out_data_o, busy_o
  );
endinterface

// File: rtl/sym_fir_tdm.sv
// Symmetric FIR sharing one pre-add/multiply/accumulate datapath across taps and channels.
// Only the unique half of the coefficients is stored; the centre tap is coef[U-1].
module sym_fir_tdm #(
  parameter int WD    = 24,
  parameter int N_TAP = 32,
  parameter int N_CH  = 2,
  parameter int SHIFT = 22
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  sym_fir_tdm_if.slave  bus
);
  localparam int U    = N_TAP / 2 + 1;
  localparam int AW   = (U > 1) ? $clog2(U) : 1;
  localparam int TW   = $clog2(N_TAP + 1);
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW   = 2 * WD + 1;
  localparam int ACCW = PW + $clog2(U);

  localparam logic signed [WD-1:0]   COEF_ONE = {{(WD-1){1'b0}}, 1'b1} << SHIFT;
  localparam logic signed [ACCW-1:0] RND_HALF = {{(ACCW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX  = {{(ACCW-WD+1){1'b0}}, {(WD-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN  = {{(ACCW-WD+1){1'b1}}, {(WD-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           ch_r;
  logic [AW-1:0]           k_r;
  logic signed [ACCW-1:0]  acc_r;
  logic signed [WD-1:0]    x_r    [N_CH][N_TAP+1];
  logic signed [WD-1:0]    coef_r [U];
  logic signed [WD-1:0]    slot_r [N_CH];
  logic [N_CH*WD-1:0]      out_data_r;
  logic                    out_valid_r;

  logic                    accept_s;
  logic                    coef_wr_s;
  logic [TW-1:0]           lo_idx_s;
  logic [TW-1:0]           hi_idx_s;
  logic signed [WD-1:0]    lo_s;
  logic signed [WD-1:0]    hi_s;
  logic signed [WD:0]      pre_s;
  logic signed [WD-1:0]    coef_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [ACCW-1:0]  rnd_s;
  logic signed [WD-1:0]    sat_s;
  logic [N_CH*WD-1:0]      pack_s;

  assign bus.in_ready_o  = (state_r == IDLE) & en_i & ~rst_i;
  assign bus.out_valid_o = out_valid_r;
  assign bus.out_data_o  = out_data_r;
  assign bus.busy_o      = (state_r != IDLE);

  assign accept_s  = bus.in_valid_i & bus.in_ready_o;
  assign coef_wr_s = bus.coef_we_i & (state_r == IDLE) &
                     ({1'b0, bus.coef_addr_i} < (AW+1)'(U));

  // Folded tap pair, product, rounding/saturation and the packed output frame.
  always_comb begin
    lo_idx_s = TW'(k_r);
    hi_idx_s = TW'(N_TAP) - lo_idx_s;
    lo_s     = x_r[ch_r][lo_idx_s];
    hi_s     = x_r[ch_r][hi_idx_s];
    if (k_r == AW'(U - 1)) begin
      pre_s = {lo_s[WD-1], lo_s};
    end else begin
      pre_s = {lo_s[WD-1], lo_s} + {hi_s[WD-1], hi_s};
    end
    coef_s = coef_r[k_r];
    prod_s = PW'(pre_s) * PW'(coef_s);
    rnd_s  = (acc_r + RND_HALF) >>> SHIFT;
    if (rnd_s > SAT_MAX) begin
      sat_s = SAT_MAX[WD-1:0];
    end else if (rnd_s < SAT_MIN) begin
      sat_s = SAT_MIN[WD-1:0];
    end else begin
      sat_s = rnd_s[WD-1:0];
    end
    pack_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (c == N_CH - 1) begin
        pack_s[c*WD +: WD] = sat_s;
      end else begin
        pack_s[c*WD +: WD] = slot_r[c];
      end
    end
  end

  // Control FSM with delay lines, coefficient store, accumulator and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      ch_r        <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        slot_r[c] <= '0;
        for (int i = 0; i <= N_TAP; i++) begin
          x_r[c][i] <= '0;
        end
      end
      for (int k = 0; k < U; k++) begin
        coef_r[k] <= (k == U - 1) ? COEF_ONE : '0;
      end
    end else if (!en_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (coef_wr_s) begin
        coef_r[bus.coef_addr_i] <= bus.coef_data_i;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int c = 0; c < N_CH; c++) begin
              for (int i = N_TAP; i > 0; i--) begin
                x_r[c][i] <= x_r[c][i-1];
              end
              x_r[c][0] <= bus.in_data_i[c*WD +: WD];
            end
            ch_r    <= '0;
            k_r     <= '0;
            acc_r   <= '0;
            state_r <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_r + ACCW'(prod_s);
          if (k_r == AW'(U - 1)) begin
            state_r <= FIN;
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        FIN: begin
          slot_r[ch_r] <= sat_s;
          acc_r        <= '0;
          if (ch_r == CW'(N_CH - 1)) begin
            out_data_r  <= pack_s;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            ch_r    <= ch_r + 1'b1;
            k_r     <= '0;
            state_r <= MAC;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
